// File: rtl/t01_tetris_pkg.sv
// rtl/t01_tetris_pkg.sv - piece, pattern and state definitions for the placement streamer
// Purpose: shared types and lookup helpers for the placement enumerator.
//   piece_e        : piece codes (7 = none)
//   state_e        : enumerator FSM states
//   piece_pattern  : (type, rotation) -> 4x4 top-left justified pattern, bit [r*4+c]
//   rot_count      : number of distinct rotations per piece
//   pattern_width  : occupied column span of a pattern
package t01_tetris_pkg;

  typedef enum logic [2:0] {
    PIECE_I    = 3'd0,
    PIECE_O    = 3'd1,
    PIECE_S    = 3'd2,
    PIECE_Z    = 3'd3,
    PIECE_J    = 3'd4,
    PIECE_L    = 3'd5,
    PIECE_T    = 3'd6,
    PIECE_NONE = 3'd7
  } piece_e;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_LOAD  = 3'd1,
    ST_PROBE = 3'd2,
    ST_DROP  = 3'd3,
    ST_MERGE = 3'd4,
    ST_EMIT  = 3'd5,
    ST_NEXT  = 3'd6,
    ST_DONE  = 3'd7
  } state_e;

  // Rotation 0 of I is vertical so the vertical placements are scanned first.
  function automatic logic [15:0] piece_pattern(input logic [2:0] ptype, input logic [1:0] rot);
    logic [15:0] p;
    p = 16'h0000;
    case (piece_e'(ptype))
      PIECE_I: p = rot[0] ? 16'h000F : 16'h1111;
      PIECE_O: p = 16'h0033;
      PIECE_S: p = rot[0] ? 16'h0231 : 16'h0036;
      PIECE_Z: p = rot[0] ? 16'h0132 : 16'h0063;
      PIECE_J: begin
        case (rot)
          2'd0:    p = 16'h0071;
          2'd1:    p = 16'h0113;
          2'd2:    p = 16'h0047;
          default: p = 16'h0322;
        endcase
      end
      PIECE_L: begin
        case (rot)
          2'd0:    p = 16'h0074;
          2'd1:    p = 16'h0311;
          2'd2:    p = 16'h0017;
          default: p = 16'h0223;
        endcase
      end
      PIECE_T: begin
        case (rot)
          2'd0:    p = 16'h0072;
          2'd1:    p = 16'h0131;
          2'd2:    p = 16'h0027;
          default: p = 16'h0232;
        endcase
      end
      default: p = 16'h0000;
    endcase
    return p;
  endfunction

  function automatic logic [2:0] rot_count(input logic [2:0] ptype);
    logic [2:0] n;
    case (piece_e'(ptype))
      PIECE_O:                   n = 3'd1;
      PIECE_I, PIECE_S, PIECE_Z: n = 3'd2;
      PIECE_J, PIECE_L, PIECE_T: n = 3'd4;
      default:                   n = 3'd0;
    endcase
    return n;
  endfunction

  function automatic logic [2:0] pattern_width(input logic [15:0] p);
    logic [3:0] cols;
    logic [2:0] w;
    cols = p[3:0] | p[7:4] | p[11:8] | p[15:12];
    if (cols[3])      w = 3'd4;
    else if (cols[2]) w = 3'd3;
    else if (cols[1]) w = 3'd2;
    else if (cols[0]) w = 3'd1;
    else              w = 3'd0;
    return w;
  endfunction

endpackage

// File: rtl/t01_ai_placement_streamer_if.sv
// rtl/t01_ai_placement_streamer_if.sv - candidate stream interface of the placement streamer
// Purpose: valid/ready candidate port.
//   out_valid/out_ready : handshake
//   out_board           : resulting board, bit row*BOARD_W+col
//   out_rotation/out_x  : placement of the candidate
//   out_lines           : full rows produced (0..4)
//   out_last            : final candidate of the enumeration
interface t01_ai_placement_streamer_if #(
  parameter int BOARD_W = 10,
  parameter int BOARD_H = 20
);
  localparam int X_W = $clog2(BOARD_W);

  logic                         out_valid;
  logic                         out_ready;
  logic [BOARD_W*BOARD_H-1:0]   out_board;
  logic [1:0]                   out_rotation;
  logic [X_W-1:0]               out_x;
  logic [2:0]                   out_lines;
  logic                         out_last;

  modport master (
    output out_valid, out_board, out_rotation, out_x, out_lines, out_last,
    input  out_ready
  );

  modport slave (
    input  out_valid, out_board, out_rotation, out_x, out_lines, out_last,
    output out_ready
  );
endinterface

// File: rtl/t01_placement_line_clear.sv
// rtl/t01_placement_line_clear.sv - full-row counter and row compactor
// Purpose: combinational; counts full rows of a merged board and removes them,
//   shifting the rows above down and zero-filling the vacated top rows.
//   merged_board : board after the piece is OR-ed in
//   clear_board  : compacted board
//   full_rows    : number of full rows, saturated at 4
module t01_placement_line_clear #(
  parameter int BOARD_W = 10,
  parameter int BOARD_H = 20
) (
  input  logic [BOARD_W*BOARD_H-1:0] merged_board,
  output logic [BOARD_W*BOARD_H-1:0] clear_board,
  output logic [2:0]                 full_rows
);
  localparam int CELL_W = $clog2(BOARD_W*BOARD_H);

  always_comb begin
    int n_full;
    int dst;
    clear_board = '0;
    n_full      = 0;
    dst         = BOARD_H - 1;
    // Walk bottom-up; every surviving row is copied to the next free slot from the bottom.
    for (int r = BOARD_H - 1; r >= 0; r--) begin
      if (&merged_board[CELL_W'(r*BOARD_W) +: BOARD_W]) begin
        n_full++;
      end else begin
        clear_board[CELL_W'(dst*BOARD_W) +: BOARD_W] = merged_board[CELL_W'(r*BOARD_W) +: BOARD_W];
        dst--;
      end
    end
    full_rows = (n_full > 4) ? 3'd4 : 3'(n_full);
  end
endmodule

// File: rtl/t01_ai_placement_streamer.sv
// rtl/t01_ai_placement_streamer.sv - placement enumerator streaming one candidate board at a time
// Purpose: for a latched board and piece, walks every (rotation, x), drops the piece row by row,
//   merges it (optionally clearing full rows) and streams each legal result.
//   clk, reset          : clock, asynchronous active-high reset
//   start, abort        : begin enumeration (IDLE only) / synchronous cancel
//   board_in, piece_type: latched on accepted start
//   busy, done, count   : activity, end-of-enumeration pulse, accepted candidates
//   out_if (master)     : candidate stream
module t01_ai_placement_streamer
  import t01_tetris_pkg::*;
#(
  parameter int BOARD_W     = 10,
  parameter int BOARD_H     = 20,
  parameter int CLEAR_LINES = 1
) (
  input  logic                               clk,
  input  logic                               reset,
  input  logic                               start,
  input  logic                               abort,
  input  logic [BOARD_W*BOARD_H-1:0]         board_in,
  input  logic [2:0]                         piece_type,
  output logic                               busy,
  output logic                               done,
  output logic [$clog2(4*BOARD_W+1)-1:0]     count,
  t01_ai_placement_streamer_if.master        out_if
);
  localparam int N      = BOARD_W * BOARD_H;
  localparam int CELL_W = $clog2(N);
  localparam int X_W    = $clog2(BOARD_W);
  localparam int C_W    = $clog2(4*BOARD_W+1);
  localparam int ROW_W  = $clog2(BOARD_H);

  typedef struct packed {
    logic           ok;
    logic [1:0]     rot;
    logic [X_W-1:0] x;
  } pos_t;

  function automatic logic fits(input logic [N-1:0] b, input logic [15:0] p,
                                input int col0, input int row0);
    logic ok;
    ok = 1'b1;
    for (int r = 0; r < 4; r++) begin
      for (int c = 0; c < 4; c++) begin
        if (p[4'(r*4+c)]) begin
          if ((row0 + r) >= BOARD_H || (col0 + c) >= BOARD_W) ok = 1'b0;
          else if (b[CELL_W'((row0 + r)*BOARD_W + col0 + c)]) ok = 1'b0;
        end
      end
    end
    return ok;
  endfunction

  // Scan-order successor of (rot, x); ok=0 when (rot, x) is the final position.
  function automatic pos_t next_pos(input logic [2:0] ptype, input logic [1:0] rot,
                                    input logic [X_W-1:0] x);
    pos_t           n;
    logic [X_W-1:0] mx;
    mx    = X_W'(BOARD_W - int'(pattern_width(piece_pattern(ptype, rot))));
    n.ok  = 1'b1;
    n.rot = rot;
    n.x   = x + X_W'(1);
    if (x >= mx) begin
      n.x   = '0;
      n.rot = rot + 2'd1;
      n.ok  = (({1'b0, rot} + 3'd1) < rot_count(ptype));
    end
    return n;
  endfunction

  state_e         state_q, state_d;
  logic [N-1:0]   board_q, board_d;
  logic [2:0]     piece_q, piece_d;
  logic [1:0]     rot_q, rot_d;
  logic [X_W-1:0] x_q, x_d;
  logic [X_W-1:0] max_x_q, max_x_d;
  logic [ROW_W-1:0] row_q, row_d;
  logic [15:0]    pat_q, pat_d;
  logic [C_W-1:0] count_q, count_d;
  logic [N-1:0]   out_board_q, out_board_d;
  logic [2:0]     out_lines_q, out_lines_d;
  logic           last_q, last_d;
  logic [1:0]     la_rot_q, la_rot_d;
  logic [X_W-1:0] la_x_q, la_x_d;
  logic           la_done_q, la_done_d;

  logic [15:0]    load_pat, la_pat;
  pos_t           cur_nxt, la_nxt;
  logic [N-1:0]   placed, merged, cleared;
  logic [2:0]     full_rows;

  assign load_pat = piece_pattern(piece_q, rot_q);
  assign la_pat   = piece_pattern(piece_q, la_rot_q);
  assign cur_nxt  = next_pos(piece_q, rot_q, x_q);
  assign la_nxt   = next_pos(piece_q, la_rot_q, la_x_q);

  always_comb begin
    placed = '0;
    for (int r = 0; r < 4; r++) begin
      for (int c = 0; c < 4; c++) begin
        if (pat_q[4'(r*4+c)] && (int'(row_q) + r) < BOARD_H && (int'(x_q) + c) < BOARD_W)
          placed[CELL_W'((int'(row_q) + r)*BOARD_W + int'(x_q) + c)] = 1'b1;
      end
    end
  end

  assign merged = board_q | placed;

  t01_placement_line_clear #(.BOARD_W(BOARD_W), .BOARD_H(BOARD_H)) u_line_clear (
    .merged_board (merged),
    .clear_board  (cleared),
    .full_rows    (full_rows)
  );

  always_comb begin
    state_d     = state_q;
    board_d     = board_q;
    piece_d     = piece_q;
    rot_d       = rot_q;
    x_d         = x_q;
    max_x_d     = max_x_q;
    row_d       = row_q;
    pat_d       = pat_q;
    count_d     = count_q;
    out_board_d = out_board_q;
    out_lines_d = out_lines_q;
    last_d      = last_q;
    la_rot_d    = la_rot_q;
    la_x_d      = la_x_q;
    la_done_d   = la_done_q;

    case (state_q)
      ST_IDLE: begin
        if (start && !abort) begin
          board_d = board_in;
          piece_d = piece_type;
          count_d = '0;
          rot_d   = '0;
          x_d     = '0;
          state_d = (piece_type == PIECE_NONE) ? ST_DONE : ST_LOAD;
        end
      end
      ST_LOAD: begin
        pat_d   = load_pat;
        max_x_d = X_W'(BOARD_W - int'(pattern_width(load_pat)));
        state_d = ST_PROBE;
      end
      ST_PROBE: begin
        row_d   = '0;
        state_d = fits(board_q, pat_q, int'(x_q), 0) ? ST_DROP : ST_NEXT;
      end
      ST_DROP: begin
        if (fits(board_q, pat_q, int'(x_q), int'(row_q) + 1)) row_d = row_q + ROW_W'(1);
        else                                                 state_d = ST_MERGE;
      end
      ST_MERGE: begin
        out_board_d = (CLEAR_LINES != 0) ? cleared : merged;
        out_lines_d = full_rows;
        // Seed the look-ahead with the successor position; none means this one is last.
        la_rot_d    = cur_nxt.rot;
        la_x_d      = cur_nxt.x;
        la_done_d   = !cur_nxt.ok;
        last_d      = !cur_nxt.ok;
        state_d     = ST_EMIT;
      end
      ST_EMIT: begin
        // out_valid is held low until the look-ahead settles, so out_last never changes under valid.
        if (!la_done_q) begin
          if (fits(board_q, la_pat, int'(la_x_q), 0)) begin
            last_d    = 1'b0;
            la_done_d = 1'b1;
          end else if (la_nxt.ok) begin
            la_rot_d = la_nxt.rot;
            la_x_d   = la_nxt.x;
          end else begin
            last_d    = 1'b1;
            la_done_d = 1'b1;
          end
        end else if (out_if.out_ready) begin
          count_d = count_q + C_W'(1);
          state_d = ST_NEXT;
        end
      end
      ST_NEXT: begin
        if (x_q < max_x_q) begin
          x_d     = x_q + X_W'(1);
          state_d = ST_PROBE;
        end else if (({1'b0, rot_q} + 3'd1) < rot_count(piece_q)) begin
          rot_d   = rot_q + 2'd1;
          x_d     = '0;
          state_d = ST_LOAD;
        end else begin
          state_d = ST_DONE;
        end
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase

    // Abort beats everything, including a coincident handshake.
    if (abort) begin
      state_d = ST_IDLE;
      count_d = count_q;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= ST_IDLE;
      board_q     <= '0;
      piece_q     <= '0;
      rot_q       <= '0;
      x_q         <= '0;
      max_x_q     <= '0;
      row_q       <= '0;
      pat_q       <= '0;
      count_q     <= '0;
      out_board_q <= '0;
      out_lines_q <= '0;
      last_q      <= 1'b0;
      la_rot_q    <= '0;
      la_x_q      <= '0;
      la_done_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      board_q     <= board_d;
      piece_q     <= piece_d;
      rot_q       <= rot_d;
      x_q         <= x_d;
      max_x_q     <= max_x_d;
      row_q       <= row_d;
      pat_q       <= pat_d;
      count_q     <= count_d;
      out_board_q <= out_board_d;
      out_lines_q <= out_lines_d;
      last_q      <= last_d;
      la_rot_q    <= la_rot_d;
      la_x_q      <= la_x_d;
      la_done_q   <= la_done_d;
    end
  end

  assign busy                = (state_q != ST_IDLE) && (state_q != ST_DONE);
  assign done                = (state_q == ST_DONE);
  assign count               = count_q;
  assign out_if.out_valid    = (state_q == ST_EMIT) && la_done_q;
  assign out_if.out_board    = out_board_q;
  assign out_if.out_rotation = rot_q;
  assign out_if.out_x        = x_q;
  assign out_if.out_lines    = out_lines_q;
  assign out_if.out_last     = last_q;
endmodule
